// File: rtl/timer_pkg.sv
// Shared timer types: FSM state encoding and default counter width.
package timer_pkg;

    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } tmr_state_t;

endpackage

// File: rtl/down_timer_4b.sv
// Loadable down-counter/timer with expiry pulse and cascadable borrow (tc).
// Define DOWN_TIMER_AUTO_RELOAD_EN to free-run by reloading from reload_q on expiry.
module down_timer_4b
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] din,
    input  logic             cten,
    output logic [CNT_W-1:0] out,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    tmr_state_t       state_q, state_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // State, count and reload registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state: hold by default, done only on the decrement out of 1
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: ;
            COUNT: begin
                if (cten) begin
                    if (out_q > CNT_W'(1)) begin
                        out_d = out_q - CNT_W'(1);
                    end else if (out_q == CNT_W'(1)) begin
                        done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        out_d  = reload_q;
`else
                        out_d   = '0;
                        state_d = EXPIRED;
`endif
                    end else begin
                        // Zero count in COUNT is unreachable; park safely without a pulse
                        state_d = EXPIRED;
                    end
                end
            end
            EXPIRED: ;
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase

        // Load overrides everything, including a same-cycle decrement
        if (ld) begin
            reload_d = din;
            out_d    = din;
            done_d   = 1'b0;
            state_d  = (din != '0) ? COUNT : EXPIRED;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign tc   = cten & (out_q == '0);
    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_down_timer_4b.sv
// Scoreboard bench for down_timer_4b: stimulus pushes per-cycle expectations, monitor pops and checks.
module tb_down_timer_4b;

    localparam int unsigned W = 4;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         ld;
    logic [W-1:0] din;
    logic         cten;
    logic [W-1:0] out;
    logic         tc;
    logic         done;
    logic         busy;

    typedef struct {
        logic [W-1:0] o;
        logic         d;
        logic         b;
        logic         t;
        string        nm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    down_timer_4b #(.CNT_W(W)) dut (
        .clk  (clk),
        .clr  (clr),
        .ld   (ld),
        .din  (din),
        .cten (cten),
        .out  (out),
        .tc   (tc),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [W-1:0] eo, input logic ed,
                           input logic eb, input logic et);
        chk({nm, ".out"},  int'(out),  int'(eo));
        chk({nm, ".done"}, int'(done), int'(ed));
        chk({nm, ".busy"}, int'(busy), int'(eb));
        chk({nm, ".tc"},   int'(tc),   int'(et));
    endtask

    // Drive one cycle of inputs and queue what the outputs must read after the next edge
    task automatic step(input string nm, input logic l, input logic [W-1:0] d, input logic c,
                        input logic [W-1:0] eo, input logic ed, input logic eb);
        exp_t e;
        @(negedge clk);
        ld   = l;
        din  = d;
        cten = c;
        e.o  = eo;
        e.d  = ed;
        e.b  = eb;
        e.t  = c & (eo == '0);
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: every clock the DUT presents a new count; check against the queue head
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_all(e.nm, e.o, e.d, e.b, e.t);
        end
    end

    function automatic logic [W-1:0] exp_at_expiry(input logic [W-1:0] r);
        return AUTO ? r : '0;
    endfunction

    initial begin
        clr  = 1'b1;
        ld   = 1'b0;
        din  = '0;
        cten = 1'b1;
        #1;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        clr  = 1'b0;
        cten = 1'b0;

        // Basic count from 4
        step("basic_ld", 1'b1, 4'd4, 1'b0, 4'd4, 1'b0, 1'b1);
        step("basic_3",  1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1);
        step("basic_2",  1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b1);
        step("basic_1",  1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1);
        step("basic_exp", 1'b0, 4'd0, 1'b1, exp_at_expiry(4'd4), 1'b1, AUTO);
        step("basic_post", 1'b0, 4'd0, 1'b1, AUTO ? 4'd3 : 4'd0, 1'b0, AUTO);

        // Stall: cten 1,0,0,1,1
        step("stall_ld", 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b1);
        step("stall_a",  1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b1);
        step("stall_b",  1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1);
        step("stall_c",  1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b1);
        step("stall_d",  1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1);
        step("stall_exp", 1'b0, 4'd0, 1'b1, exp_at_expiry(4'd3), 1'b1, AUTO);
        step("stall_hold", 1'b0, 4'd0, 1'b0, AUTO ? 4'd3 : 4'd0, 1'b0, AUTO);

        // Load wins over a same-cycle decrement
        step("pri_ld7", 1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 1'b1);
        step("pri_6",   1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b1);
        step("pri_ld9", 1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b1);
        step("pri_8",   1'b0, 4'd0, 1'b1, 4'd8, 1'b0, 1'b1);
        step("pri_7",   1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b1);

        // Zero load goes straight to EXPIRED, then saturates
        step("zero_ld", 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step($sformatf("sat_%0d", i), 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Free-run versus stop after expiry
        step("ar_ld", 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (AUTO)
                step($sformatf("ar_%0d", i), 1'b0, 4'd0, 1'b1,
                     (i % 3 == 2) ? 4'd3 : W'(2 - (i % 3)), (i % 3 == 2), 1'b1);
            else
                step($sformatf("ar_%0d", i), 1'b0, 4'd0, 1'b1,
                     (i < 2) ? W'(2 - i) : 4'd0, (i == 2), (i < 2));
        end

        // Asynchronous reset in the middle of a count
        step("mid_ld5", 1'b1, 4'd5, 1'b0, 4'd5, 1'b0, 1'b1);
        step("mid_hold", 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1);
        @(posedge clk);
        #4;
        clr  = 1'b1;
        cten = 1'b1;
        #1;
        chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        clr = 1'b0;
        step("idle_ignores_cten", 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        ld   = 1'b0;
        cten = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/down_timer_4b.md
Name: down_timer_4b

Overview:
- Loadable synchronous down-counter/timer, the count-down counterpart of the team's 4-bit up counter.
- Loaded with a start value, it decrements on each enabled clock and signals expiry at zero.
- Provides a combinational borrow/terminal-count output (`tc`) so stages can be cascaded like the up counter's `tc`.
- Sits in the timer datapath wherever an interval must be timed out rather than counted up.

Parameters:
- CNT_W, 4, counter width in bits (out, din, reload register).

Ports:
- clk   input   1      system clock, all state updates on rising edge
- clr   input   1      asynchronous reset, active-high
- ld    input   1      synchronous load strobe; captures din
- din   input   CNT_W  load/reload value
- cten  input   1      count enable; decrement permitted when high
- out   output  CNT_W  current count value (registered)
- tc    output  1      terminal count / borrow: combinational, cten AND (out == 0)
- done  output  1      registered one-cycle pulse on natural expiry
- busy  output  1      high while state == COUNT

Behaviour:
- Reset (clr high, asynchronous, takes effect without a clock edge):
  - out = 0, reload register = 0, done = 0, state = IDLE.
  - busy = 0; tc = cten AND 1 (out == 0).
- States: IDLE, COUNT, EXPIRED. Encoding is 2 bits.
- ld (any state, highest synchronous priority):
  - reload_q <= din, out <= din, done <= 0.
  - state <= COUNT if din != 0, else EXPIRED.
  - ld with din == 0 does not pulse done.
- IDLE:
  - cten is ignored; out holds.
  - Exit only via ld.
- COUNT, cten = 0:
  - out holds, state holds.
- COUNT, cten = 1 and out > 1:
  - out <= out - 1.
- COUNT, cten = 1 and out == 1:
  - out <= 0, state <= EXPIRED, done <= 1 for exactly the next cycle.
- EXPIRED:
  - out holds 0; no wrap to all-ones. Decrement saturates at zero.
  - Exit only via ld.
- Simultaneous ld and cten: load wins, no decrement that cycle.
- Latency and timing:
  - Load value N (N ≥ 1) with cten held high from the cycle after ld.
  - done is asserted on the edge N cycles after the load edge.
  - out sequence: N, N-1, …, 1, 0.
- tc:
  - Purely combinational; asserted in any state when out == 0 and cten == 1.
  - Used as borrow for cascading to a higher stage's cten.
- done is 0 in every cycle other than the single expiry cycle.
- Reset mid-count aborts immediately to IDLE with out = 0; no done pulse.
- Arithmetic is unsigned CNT_W; no underflow is possible because of the saturation rule above.

Optional Feature:
- Macro: DOWN_TIMER_AUTO_RELOAD_EN.
- Defined: in COUNT with cten = 1 and out == 1:
  - out <= reload_q, state stays COUNT, done pulses one cycle.
  - The timer free-runs with a period of reload_q enabled cycles.
  - EXPIRED is reached only via ld with din == 0.
  - busy stays high while free-running.
- Not defined: behaviour exactly as in Behaviour; the timer stops in EXPIRED until the next ld.
- Port list is identical in both builds.

Decomposition:
- Shared package timer_pkg holds:
  - typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} tmr_state_t;
  - localparam CNT_W_DEF = 4.
- No sub-module: state register, count register and reload register are in one always_ff.
- tc and busy are continuous assigns.

Test Plan:
- Reset check: assert clr asynchronously mid-cycle with out = 5 in COUNT -> out = 0, state IDLE, done = 0, busy = 0 before the next edge.
- Basic count: ld with din = 4, then cten held high -> out 4,3,2,1,0 on successive edges; done high exactly one cycle (when out first reads 0); tc high from that cycle while cten = 1.
- Stall: ld 3; cten toggles 1,0,0,1,1 -> out 3,2,2,2,1,0; done pulses once; busy drops on entry to EXPIRED.
- Load priority: in COUNT with out = 6 and cten = 1, assert ld with din = 9 -> next out = 9 (not 5); subsequent counting resumes from 9.
- Zero load and saturation: ld with din = 0 -> state EXPIRED, out = 0, no done pulse; 10 cycles with cten = 1 -> out stays 0, tc = 1 throughout.
- Auto-reload (macro defined): ld 3, cten held high for 9 cycles -> out 3,2,1,3,2,1,3,2,1; done pulses every 3rd cycle; busy constantly 1. Without the macro the same stimulus stops at out = 0.
